// File: rtl/thread_regfile_pkg.sv
// +----------------------------------------------------------------------------+
// | thread_regfile_pkg : shared constants and FSM state type for thread_regfile |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package thread_regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_bank.sv
// +----------------------------------------------------------------------------+
// | regfile_bank : one 32-entry register bank, 1 write / 2 async read, x0 = 0   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_bank
    import thread_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2
);

    // Storage carries no reset; the owner zeroes it with a write sweep.
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];

endmodule

`default_nettype wire

// File: rtl/thread_regfile.sv
// +----------------------------------------------------------------------------+
// | thread_regfile : per-thread banked register file with post-reset clear     |
// | sweep. Optional macro REGFILE_BYPASS_EN adds write-to-read forwarding.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module thread_regfile
    import thread_regfile_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int NUM_THREADS  = 4,
    localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_write_w,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic [BITS_THREADS-1:0]   tid_w,
    input  logic [DATA_WIDTH-1:0]     result_w,
    input  logic [BITS_THREADS-1:0]   tid_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    output logic [DATA_WIDTH-1:0]     rd1_d,
    output logic [DATA_WIDTH-1:0]     rd2_d,
    output logic                      busy
);

    localparam logic [REG_ADDR_WIDTH-1:0] LAST_INDEX = REG_ADDR_WIDTH'(NUM_REGS - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [REG_ADDR_WIDTH-1:0] r_index;
    logic [REG_ADDR_WIDTH-1:0] w_next_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_index <= '0;
        end else begin
            r_state <= w_next_state;
            r_index <= w_next_index;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        if (r_state == CLEAR) begin
            w_next_index = r_index + REG_ADDR_WIDTH'(1);
            if (r_index == LAST_INDEX) begin
                w_next_state = READY;
            end
        end
    end

    wire w_clearing = (r_state == CLEAR);
    assign busy = w_clearing;

    // During the sweep every bank is written with zero at the sweep index;
    // writeback traffic is dropped until the sweep completes.
    wire [REG_ADDR_WIDTH-1:0] w_waddr = w_clearing ? r_index : rd_w;
    wire [DATA_WIDTH-1:0]     w_wdata = w_clearing ? '0 : result_w;

    logic [DATA_WIDTH-1:0] w_bank_rd1 [NUM_THREADS];
    logic [DATA_WIDTH-1:0] w_bank_rd2 [NUM_THREADS];

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_bank
        wire w_we = w_clearing || (reg_write_w && (tid_w == BITS_THREADS'(g)));

        regfile_bank #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk    (clk),
            .we     (w_we),
            .waddr  (w_waddr),
            .wdata  (w_wdata),
            .raddr1 (rs1_d),
            .raddr2 (rs2_d),
            .rdata1 (w_bank_rd1[g]),
            .rdata2 (w_bank_rd2[g])
        );
    end

    wire [DATA_WIDTH-1:0] w_sel_rd1 = w_bank_rd1[tid_d];
    wire [DATA_WIDTH-1:0] w_sel_rd2 = w_bank_rd2[tid_d];

`ifdef REGFILE_BYPASS_EN
    wire w_wr_hit = reg_write_w && (rd_w != '0) && (tid_w == tid_d);
    wire w_byp1   = w_wr_hit && (rd_w == rs1_d);
    wire w_byp2   = w_wr_hit && (rd_w == rs2_d);
`else
    wire w_byp1   = 1'b0;
    wire w_byp2   = 1'b0;
`endif

    assign rd1_d = w_clearing ? '0 : (w_byp1 ? result_w : w_sel_rd1);
    assign rd2_d = w_clearing ? '0 : (w_byp2 ? result_w : w_sel_rd2);

endmodule

`default_nettype wire

// File: tb/tb_thread_regfile.sv
// Directed self-checking bench for thread_regfile (default 32-bit, 4 threads).
`default_nettype none

module tb_thread_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_write_w = 1'b0;
    logic [4:0]  rd_w = '0;
    logic [1:0]  tid_w = '0;
    logic [31:0] result_w = '0;
    logic [1:0]  tid_d = '0;
    logic [4:0]  rs1_d = '0;
    logic [4:0]  rs2_d = '0;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thread_regfile #(
        .DATA_WIDTH  (32),
        .NUM_THREADS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_write_w (reg_write_w),
        .rd_w        (rd_w),
        .tid_w       (tid_w),
        .result_w    (result_w),
        .tid_d       (tid_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd1_d       (rd1_d),
        .rd2_d       (rd2_d),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] t, input logic [4:0] r, input logic [31:0] d);
        reg_write_w = 1'b1;
        tid_w       = t;
        rd_w        = r;
        result_w    = d;
        tick();
        reg_write_w = 1'b0;
    endtask

    // Counts rising edges from release until busy drops, bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int t = 0; t < 4; t++) begin
            for (int r = 1; r < 32; r++) begin
                tid_d = 2'(t);
                rs1_d = 5'(r);
                rs2_d = 5'(r);
                #1;
                total++;
                if (rd1_d !== 32'h0 || rd2_d !== 32'h0) begin
                    bad++;
                    $display("FAIL %s t=%0d r=%0d: rd1=%h rd2=%h required 0", tag, t, r, rd1_d, rd2_d);
                end
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        #1;
        total++;
        if (busy !== 1'b1 || rd1_d !== 32'h0 || rd2_d !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b rd1=%h rd2=%h required 1/0/0", busy, rd1_d, rd2_d);
        end
        tick();
        tick();
        rst_n = 1'b1;
        count_busy(cnt);
        total++;
        if (cnt != 32) begin
            bad++;
            $display("FAIL reset_busy_len: got %0d cycles required 32", cnt);
        end
        check_all_zero("reset_sweep");
    endtask

    task automatic test_write_read();
        write_reg(2'd2, 5'd5, 32'hDEADBEEF);
        tid_d = 2'd2; rs1_d = 5'd5; rs2_d = 5'd0;
        #1;
        total++;
        if (rd1_d !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_rd_tid2: got %h required deadbeef", rd1_d);
        end
        tid_d = 2'd1;
        #1;
        total++;
        if (rd1_d !== 32'h0) begin
            bad++;
            $display("FAIL wr_rd_tid1_isolated: got %h required 0", rd1_d);
        end
        tid_d = 2'd2; rs2_d = 5'd5;
        #1;
        total++;
        if (rd2_d !== 32'hDEADBEEF || rd1_d !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL both_ports_same_addr: rd1=%h rd2=%h required deadbeef", rd1_d, rd2_d);
        end
    endtask

    task automatic test_x0();
        for (int t = 0; t < 4; t++) write_reg(2'(t), 5'd0, 32'h12345678);
        for (int t = 0; t < 4; t++) begin
            tid_d = 2'(t); rs1_d = 5'd0; rs2_d = 5'd0;
            #1;
            total++;
            if (rd1_d !== 32'h0 || rd2_d !== 32'h0) begin
                bad++;
                $display("FAIL x0_read t=%0d: rd1=%h rd2=%h required 0", t, rd1_d, rd2_d);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h0;
`endif
        reg_write_w = 1'b1; tid_w = 2'd3; rd_w = 5'd7; result_w = 32'hA5A5A5A5;
        tid_d = 2'd3; rs1_d = 5'd1; rs2_d = 5'd7;
        #1;
        total++;
        if (rd2_d !== exp_same) begin
            bad++;
            $display("FAIL same_cycle_rd2: got %h required %h", rd2_d, exp_same);
        end
        total++;
        if (rd1_d !== 32'h0) begin
            bad++;
            $display("FAIL same_cycle_other_reg: got %h required 0", rd1_d);
        end
        tid_d = 2'd2;
        #1;
        total++;
        if (rd2_d !== 32'h0) begin
            bad++;
            $display("FAIL same_cycle_other_tid: got %h required 0", rd2_d);
        end
        tick();
        reg_write_w = 1'b0;
        tid_d = 2'd3;
        #1;
        total++;
        if (rd2_d !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL same_cycle_after: got %h required a5a5a5a5", rd2_d);
        end
    endtask

    task automatic test_clear_behaviour();
        int cnt;
        // Populate registers on both sides of the later mid-sweep reset point.
        write_reg(2'd1, 5'd31, 32'h00001111);
        write_reg(2'd0, 5'd1,  32'h00002222);
        write_reg(2'd2, 5'd20, 32'h00003333);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || rd1_d !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: busy=%b rd1=%h required 1/0", busy, rd1_d);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tid_d = 2'd3; rs1_d = 5'd7; rs2_d = 5'd7;
        #1;
        total++;
        if (rd1_d !== 32'h0 || rd2_d !== 32'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_read_forced: rd1=%h rd2=%h busy=%b required 0/0/1", rd1_d, rd2_d, busy);
        end
        for (int i = 3; i < 10; i++) tick();
        write_reg(2'd0, 5'd4, 32'h00000055);
        for (int i = 11; i < 20; i++) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_clear_reset_busy: got %b required 1", busy);
        end
        tick();
        rst_n = 1'b1;
        count_busy(cnt);
        total++;
        if (cnt != 32) begin
            bad++;
            $display("FAIL mid_clear_busy_len: got %0d cycles required 32", cnt);
        end
        tid_d = 2'd0; rs1_d = 5'd4; rs2_d = 5'd1;
        #1;
        total++;
        if (rd1_d !== 32'h0 || rd2_d !== 32'h0) begin
            bad++;
            $display("FAIL write_during_clear: rd1=%h rd2=%h required 0", rd1_d, rd2_d);
        end
        check_all_zero("mid_clear_sweep");
    endtask

    task automatic test_back_to_back();
        write_reg(2'd0, 5'd3, 32'h11111111);
        write_reg(2'd0, 5'd3, 32'h22222222);
        write_reg(2'd1, 5'd3, 32'h33333333);
        tid_d = 2'd0; rs1_d = 5'd3; rs2_d = 5'd0;
        #1;
        total++;
        if (rd1_d !== 32'h22222222) begin
            bad++;
            $display("FAIL b2b_overwrite: got %h required 22222222", rd1_d);
        end
        tid_d = 2'd1; rs2_d = 5'd3;
        #1;
        total++;
        if (rd2_d !== 32'h33333333) begin
            bad++;
            $display("FAIL b2b_tid1: got %h required 33333333", rd2_d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_same_cycle();
        test_clear_behaviour();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/thread_regfile.md
THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_THREADS, default 4, meaning hardware thread count (power of two); BITS_THREADS = $clog2(NUM_THREADS).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port reg_write_w  input  1  writeback write enable.
REQ-006 SHALL have port rd_w  input  5  writeback destination register.
REQ-007 SHALL have port tid_w  input  BITS_THREADS  writeback thread id.
REQ-008 SHALL have port result_w  input  DATA_WIDTH  writeback data.
REQ-009 SHALL have port tid_d  input  BITS_THREADS  decode-stage thread id for reads.
REQ-010 SHALL have ports rs1_d, rs2_d  input  5 each  decode read addresses.
REQ-011 SHALL have ports rd1_d, rd2_d  output  DATA_WIDTH each  read data.
REQ-012 SHALL have port busy  output  1  high while post-reset clear runs.

Function
REQ-013 SHALL store NUM_THREADS banks of 32 x DATA_WIDTH registers; bank selected by thread id.
REQ-014 SHALL write result_w to bank tid_w entry rd_w at rising clk when reg_write_w=1, rd_w!=0, state READY.
REQ-015 SHALL ignore writes to x0; reads of x0 SHALL return 0 in every bank, every state.
REQ-016 SHALL read combinationally: rd1_d/rd2_d = bank tid_d entry rs1_d/rs2_d, zero read latency.
REQ-017 SHALL implement two-state FSM CLEAR/READY; CLEAR entered on reset, 5-bit clear index starts at 0.
REQ-018 In CLEAR, SHALL zero entry <index> in all banks each cycle, increment index, go READY after index 31 (32 cycles total), busy=1 throughout.
REQ-019 In CLEAR, SHALL drop writeback writes and drive rd1_d=rd2_d=0.
REQ-020 SHALL drive busy=0 in READY; READY is terminal until next reset.
REQ-021 Simultaneous write and read of same tid/register in READY SHALL return old value unless REGFILE_BYPASS_EN defined (REQ-026).
REQ-022 Two read ports SHALL be independent; rs1_d=rs2_d SHALL return identical data.

Reset
REQ-023 rst_n low SHALL immediately force state CLEAR, index 0, busy=1, rd1_d=rd2_d=0, independent of clk.
REQ-024 Storage array SHALL NOT be asynchronously reset; zeroing is done solely by the CLEAR sweep.
REQ-025 Reset asserted mid-CLEAR SHALL restart sweep at index 0 and full 32-cycle duration.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: when READY, reg_write_w=1, rd_w!=0, tid_w=tid_d and rd_w=rsN_d, rdN_d SHALL equal result_w same cycle; undefined: no bypass, read returns stored value (REQ-021).

Structure
REQ-027 Shared package SHALL hold REG_ADDR_WIDTH=5, NUM_REGS=32, and the FSM state enum (CLEAR, READY).
REQ-028 One sub-module regfile_bank (single 32-entry bank, one write, two read ports, x0 hardwired zero) SHALL be instantiated NUM_THREADS times; FSM and bypass live in top.

Verification
REQ-029 Reset release -> busy=1 exactly 32 cycles, then 0; all 4x31 registers read 0.
REQ-030 READY, write tid=2 rd=5 data 0xDEADBEEF -> next cycle tid_d=2 rs1=5 gives 0xDEADBEEF; tid_d=1 rs1=5 gives 0.
REQ-031 Write rd=0 data 0x12345678 any tid -> rs1=0, rs2=0 read 0.
REQ-032 Same-cycle write tid=3 rd=7 0xA5A5A5A5 with read tid_d=3 rs2=7 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, prior value (0) without.
REQ-033 Write during CLEAR (cycle 10, rd=4 0x55) -> after READY, rd 4 reads 0.
REQ-034 rst_n pulsed low at CLEAR cycle 20 after registers written -> busy stays high 32 cycles from release, all registers 0.
